// File: rtl/sram_capture_buf.sv
// sram_capture_buf
//
// Circular sample-capture memory (2^ADDR_W words x DATA_W bits) shared between
// the Wishbone slave's SRAM bus port and a streaming sample source. Software
// arms the block, samples stream in circularly until a trigger plus a
// programmable number of post-trigger samples have been written, then the
// block parks in DONE so the window can be read back over the bus.
//
// Ports:
//   clk_i         system clock
//   rst_n_i       asynchronous active-low reset
//   mymem_addr_i  bus word address (byte address bits [ADDR_W+1:2])
//   mymem_data_i  bus write data
//   mymem_wr_i    bus write strobe (single cycle)
//   mymem_data_o  bus read data, registered, 1-cycle latency, read-first
//   smp_valid_i   sample strobe
//   smp_data_i    sample word
//   arm_i         start/restart acquisition
//   trig_i        trigger pulse (honoured only while ARMED)
//   post_cnt_i    post-trigger sample count, sampled on the trigger
//   state_o       FSM state: IDLE=0, ARMED=1, POST=2, DONE=3
//   done_o        high while in DONE
//   trig_addr_o   write pointer captured at the trigger
//   wrap_o        sticky: write pointer wrapped during this acquisition
//   wr_ign_o      sticky: a bus write was dropped during capture

module sram_capture_buf #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W+1:2] mymem_addr_i,
    input  logic [DATA_W-1:0] mymem_data_i,
    input  logic              mymem_wr_i,
    output logic [DATA_W-1:0] mymem_data_o,
    input  logic              smp_valid_i,
    input  logic [DATA_W-1:0] smp_data_i,
    input  logic              arm_i,
    input  logic              trig_i,
    input  logic [ADDR_W-1:0] post_cnt_i,
    output logic [1:0]        state_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] trig_addr_o,
    output logic              wrap_o,
    output logic              wr_ign_o
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic              wrap_q, wrap_d;
    logic              wr_ign_q, wr_ign_d;
    logic              bus_we;
    logic              cap_we;

    logic [DATA_W-1:0] mem [DEPTH];

    // Control: next-state and write enables
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        trig_addr_d = trig_addr_q;
        remaining_d = remaining_q;
        wrap_d      = wrap_q;
        wr_ign_d    = wr_ign_q;
        bus_we      = 1'b0;
        cap_we      = 1'b0;

        if (arm_i) begin
            // Arm (or restart) from any state; a coincident trigger is ignored
            // and a coincident sample is not captured.
            state_d  = ARMED;
            wr_ptr_d = '0;
            wrap_d   = 1'b0;
            wr_ign_d = 1'b0;
            bus_we   = mymem_wr_i && (state_q == IDLE || state_q == DONE);
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    bus_we = mymem_wr_i;
                end
                ARMED, POST: begin
                    if (mymem_wr_i) begin
                        wr_ign_d = 1'b1;
                    end
                    if (smp_valid_i) begin
                        cap_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (wr_ptr_q == '1) begin
                            wrap_d = 1'b1;
                        end
                    end
                    if (state_q == ARMED) begin
                        if (trig_i) begin
                            // A trigger-cycle sample lands at wr_ptr_q, so the
                            // pointer before increment is the trigger address
                            // whether or not a sample arrives this cycle.
                            trig_addr_d = wr_ptr_q;
                            if (post_cnt_i == '0) begin
                                state_d = DONE;
                            end else begin
                                remaining_d = post_cnt_i;
                                state_d     = POST;
                            end
                        end
                    end else if (smp_valid_i) begin
                        remaining_d = remaining_q - 1'b1;
                        if (remaining_q == ADDR_W'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            trig_addr_q <= '0;
            remaining_q <= '0;
            wrap_q      <= 1'b0;
            wr_ign_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            trig_addr_q <= trig_addr_d;
            remaining_q <= remaining_d;
            wrap_q      <= wrap_d;
            wr_ign_q    <= wr_ign_d;
        end
    end

    // Memory array: not reset. Bus and capture writes are mutually exclusive
    // by state, so only one write port is active in any cycle.
    always_ff @(posedge clk_i) begin
        if (bus_we) begin
            mem[mymem_addr_i] <= mymem_data_i;
        end
        if (cap_we) begin
            mem[wr_ptr_q] <= smp_data_i;
        end
    end

    // Registered bus read; non-blocking update gives read-first behaviour
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mymem_data_o <= '0;
        end else begin
            mymem_data_o <= mem[mymem_addr_i];
        end
    end

    assign state_o     = state_q;
    assign done_o      = (state_q == DONE);
    assign trig_addr_o = trig_addr_q;
    assign wrap_o      = wrap_q;
    assign wr_ign_o    = wr_ign_q;

endmodule
